// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation encoding, chunk sizing
// and the WIDTH/STAGES legality rule used at elaboration.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand and result streams of the pipelined adder, each with its own
// valid/ready pair; master drives operands and consumes results.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/adder_stage.sv
// One pipeline stage: ripple-adds chunk IDX of the operands with the incoming
// carry and registers the beat (valid, sub, carry, operands, partial sum).
module adder_stage #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_valid,
    input  logic             d_sub,
    input  logic             d_carry,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic [WIDTH-1:0] d_s,
    output logic             q_valid,
    output logic             q_sub,
    output logic             q_carry,
    output logic             q_msbc,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic [WIDTH-1:0] q_s
);
    localparam int LSB = IDX * CHUNK;

    logic [CHUNK-1:0] sum;
    logic             carry;
    logic             msbc;
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] s_next;

    always_comb begin
        {carry, sum} = {1'b0, d_a[LSB +: CHUNK]} + {1'b0, d_b[LSB +: CHUNK]}
                     + {{CHUNK{1'b0}}, d_carry};
        // Carry into the chunk MSB, recovered from the MSB sum bit.
        msbc   = d_a[LSB+CHUNK-1] ^ d_b[LSB+CHUNK-1] ^ sum[CHUNK-1];
        s_ext  = WIDTH'(sum);
        // Chunks at and above IDX are still zero on entry, so OR merges cleanly.
        s_next = d_s | (s_ext << LSB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_sub   <= 1'b0;
            q_carry <= 1'b0;
            q_msbc  <= 1'b0;
            q_a     <= '0;
            q_b     <= '0;
            q_s     <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_sub   <= d_sub;
            q_carry <= carry;
            q_msbc  <= msbc;
            q_a     <= d_a;
            q_b     <= d_b;
            q_s     <= s_next;
        end
    end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// equal chunks, one registered chunk per stage, with valid/ready on both ends.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, STAGES dividing WIDTH");
    end

    logic [STAGES:0]            valid_c;
    logic [STAGES:0]            sub_c;
    logic [STAGES:0]            carry_c;
    logic [STAGES:0][WIDTH-1:0] a_c;
    logic [STAGES:0][WIDTH-1:0] b_c;
    logic [STAGES:0][WIDTH-1:0] s_c;
    logic [STAGES-1:0]          msbc_v;
    logic                       sub_mode;
    logic                       advance;
    logic                       unused_tail;
    op_e                        op;

    // Subtract runs as a + ~b + ~cin; the mode bit rides with its beat so the
    // last stage can turn the final carry into a borrow.
    assign op       = op_e'(bus.sub);
    assign sub_mode = (op == OP_SUB);

    assign valid_c[0] = bus.in_valid;
    assign sub_c[0]   = sub_mode;
    assign carry_c[0] = bus.cin ^ sub_mode;
    assign a_c[0]     = bus.a;
    assign b_c[0]     = sub_mode ? ~bus.b : bus.b;
    assign s_c[0]     = '0;

    // Valid/ready: a beat moves on an edge where valid & ready are both high.
    // The whole pipe shifts together whenever the output slot is empty or
    // being consumed, so in_ready never depends on in_valid and bubbles stay.
    assign advance      = !valid_c[STAGES] || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (advance),
            .d_valid (valid_c[k]),
            .d_sub   (sub_c[k]),
            .d_carry (carry_c[k]),
            .d_a     (a_c[k]),
            .d_b     (b_c[k]),
            .d_s     (s_c[k]),
            .q_valid (valid_c[k+1]),
            .q_sub   (sub_c[k+1]),
            .q_carry (carry_c[k+1]),
            .q_msbc  (msbc_v[k]),
            .q_a     (a_c[k+1]),
            .q_b     (b_c[k+1]),
            .q_s     (s_c[k+1])
        );
    end

    assign bus.out_valid = valid_c[STAGES];
    assign bus.s         = s_c[STAGES];
    assign bus.cout      = carry_c[STAGES] ^ sub_c[STAGES];
    assign bus.ovf       = carry_c[STAGES] ^ msbc_v[STAGES-1];

    // Operand copies leaving the last stage and inner MSB taps have no reader.
    assign unused_tail = ^{a_c[STAGES], b_c[STAGES], msbc_v};
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors on an 8-bit/2-stage instance and
// a random sweep over four other WIDTH/STAGES shapes, all against one model.
module tb_pipelined_adder;

    localparam int NBEATS = 10000;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   stall_cycles = 0;
    logic sweep_go = 1'b0;
    int   sweep_done = 0;

    // ---------------- reference model and check helper ----------------
    function automatic logic [63:0] model(input int w, input longint a, input longint b,
                                          input logic cin, input logic sub);
        longint m, half, sa, sb, r, sr;
        logic   c, o;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (m + 1) : a;
        sb   = (b >= half) ? b - (m + 1) : b;
        if (!sub) begin
            r  = a + b + longint'(cin);
            c  = (r > m);
            sr = sa + sb + longint'(cin);
        end else begin
            r  = a - b - longint'(cin);
            c  = (a < b + longint'(cin));
            sr = sa - sb - longint'(cin);
        end
        o = (sr < -half) || (sr > half - 1);
        return 64'(r & m) | (64'(c) << w) | (64'(o) << (w + 1));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int sweep_w(input int g);
        case (g)
            0:       return 8;
            1:       return 16;
            2:       return 32;
            default: return 5;
        endcase
    endfunction

    function automatic int sweep_s(input int g);
        case (g)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 5;
        endcase
    endfunction

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main 8-bit / 2-stage instance ----------------
    pipelined_adder_if #(.WIDTH(8)) m_if();

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    logic [9:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       hold_v = 1'b0;
    logic [9:0] hold_d;

    // scoreboard: push on accept, pop and compare on consume, every cycle
    initial begin : main_compare
        logic [63:0] mv;
        logic [9:0]  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                check("main in_ready rule", 64'(m_if.in_ready),
                      64'(!m_if.out_valid || m_if.out_ready));
                if (!m_if.in_ready) stall_cycles++;
                if (hold_v)
                    check("main stall hold", 64'({m_if.out_valid, m_if.ovf, m_if.cout, m_if.s}),
                          64'({1'b1, hold_d}));
                if (m_if.in_valid && m_if.in_ready) begin
                    mv = model(8, longint'(m_if.a), longint'(m_if.b), m_if.cin, m_if.sub);
                    exp_q.push_back(mv[9:0]);
                end
                if (m_if.out_valid && m_if.out_ready) begin
                    got_q.push_back(m_if.s);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL main unexpected beat: got s=%0h want no beat", m_if.s);
                    end else begin
                        e = exp_q.pop_front();
                        check("main result", 64'({m_if.ovf, m_if.cout, m_if.s}), 64'(e));
                    end
                end
                hold_v = m_if.out_valid && !m_if.out_ready;
                hold_d = {m_if.ovf, m_if.cout, m_if.s};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, output int waits);
        logic took;
        m_if.in_valid = 1'b1;
        m_if.a        = ta;
        m_if.b        = tb;
        m_if.cin      = tc;
        m_if.sub      = ts;
        waits         = 0;
        do begin
            @(negedge clk);
            took = m_if.in_ready;
            @(posedge clk);
            #1;
            waits++;
        end while (!took && waits < 50);
        check("send accepted", 64'(took), 64'd1);
        m_if.in_valid = 1'b0;
    endtask

    task automatic single(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic ts, input logic [7:0] es, input logic ec, input logic eo);
        int w;
        send(ta, tb, tc, ts, w);
        @(negedge clk);
        check("latency not early", 64'(m_if.out_valid), 64'd0);
        @(negedge clk);
        check("latency valid", 64'(m_if.out_valid), 64'd1);
        check("literal s", 64'(m_if.s), 64'(es));
        check("literal cout", 64'(m_if.cout), 64'(ec));
        check("literal ovf", 64'(m_if.ovf), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_if.out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("main drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_seq
        int w;
        int tput;
        rst_n          = 1'b0;
        m_if.in_valid  = 1'b0;
        m_if.a         = '0;
        m_if.b         = '0;
        m_if.cin       = 1'b0;
        m_if.sub       = 1'b0;
        m_if.out_ready = 1'b0;

        // pin the model with hand-computed values
        check("pin add wrap", model(8, 'hFF, 'h01, 1'b0, 1'b0), 64'h100);
        check("pin add ovf", model(8, 'h7F, 'h01, 1'b0, 1'b0), 64'h280);
        check("pin sub ovf", model(8, 'h80, 'h01, 1'b0, 1'b1), 64'h27F);
        check("pin sub borrow", model(8, 'h05, 'h07, 1'b0, 1'b1), 64'h1FE);
        check("pin w32 wrap", model(32, 'hFFFF_FFFF, 'h1, 1'b0, 1'b0), 64'h1_0000_0000);
        check("pin w5 ovf", model(5, 'h0F, 'h01, 1'b0, 1'b0), 64'h50);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 64'(m_if.out_valid), 64'd0);
        check("reset in_ready", 64'(m_if.in_ready), 64'd1);
        check("reset s", 64'(m_if.s), 64'd0);
        check("reset cout", 64'(m_if.cout), 64'd0);
        check("reset ovf", 64'(m_if.ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_if.out_ready = 1'b1;

        // directed vectors: a, b, cin, sub -> s, cout, ovf
        single(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        single(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        single(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        single(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        single(8'h05, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        single(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        single(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        single(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // backpressure: six beats, output stalled for three cycles
        got_q.delete();
        stall_cycles = 0;
        fork
            begin
                int bw;
                for (int i = 1; i <= 6; i++) send(8'(i), 8'(i), 1'b0, 1'b0, bw);
            end
            begin
                repeat (2) @(posedge clk);
                #1 m_if.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 m_if.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp stall cycles", 64'(stall_cycles), 64'd3);
        check("bp beat count", 64'(got_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) check("bp order", 64'(got_q[i]), 64'(2 * (i + 1)));
        end

        // full throughput with both handshakes held high
        tput = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'(i * 29), 8'(i * 7), 1'(i % 2), 1'((i >> 1) % 2), w);
            tput += w;
        end
        check("throughput cycles", 64'(tput), 64'd8);
        wait_drain();

        // reset with two beats in flight
        send(8'h01, 8'h01, 1'b0, 1'b0, w);
        send(8'h02, 8'h02, 1'b0, 1'b0, w);
        check("pre-reset out_valid", 64'(m_if.out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async reset out_valid", 64'(m_if.out_valid), 64'd0);
        check("async reset s", 64'(m_if.s), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post-reset idle", 64'(m_if.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // random parameter sweep on the other instances
        sweep_go = 1'b1;
        w = 0;
        while (sweep_done < 4 && w < 80000) begin
            @(posedge clk);
            w++;
        end
        check("sweep finished", 64'(sweep_done), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 4; g++) begin : sweep
        localparam int SW = sweep_w(g);
        localparam int SS = sweep_s(g);

        pipelined_adder_if #(.WIDTH(SW)) sif();

        pipelined_adder #(.WIDTH(SW), .STAGES(SS)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif)
        );

        logic [SW+1:0] exp_q[$];
        int            n_acc = 0;

        initial begin : drive
            logic took;
            int   guard;
            took          = 1'b0;
            guard         = 0;
            sif.in_valid  = 1'b0;
            sif.a         = '0;
            sif.b         = '0;
            sif.cin       = 1'b0;
            sif.sub       = 1'b0;
            sif.out_ready = 1'b0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            while (n_acc < NBEATS && guard < 60000) begin
                if (!sif.in_valid || took) begin
                    sif.in_valid = ($urandom_range(0, 3) != 0);
                    sif.a        = SW'($urandom());
                    sif.b        = SW'($urandom());
                    sif.cin      = 1'($urandom_range(0, 1));
                    sif.sub      = 1'($urandom_range(0, 1));
                end
                sif.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                took = sif.in_valid && sif.in_ready;
                if (took) n_acc++;
                @(posedge clk);
                #1;
                guard++;
            end
            sif.in_valid  = 1'b0;
            sif.out_ready = 1'b1;
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check($sformatf("sweep%0d beats", g), 64'(n_acc), 64'(NBEATS));
            check($sformatf("sweep%0d drained", g), 64'(exp_q.size()), 64'd0);
            sweep_done++;
        end

        initial begin : compare
            logic [63:0]   mv;
            logic [SW+1:0] e;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    check($sformatf("sweep%0d in_ready rule", g), 64'(sif.in_ready),
                          64'(!sif.out_valid || sif.out_ready));
                    if (sif.in_valid && sif.in_ready) begin
                        mv = model(SW, longint'(sif.a), longint'(sif.b), sif.cin, sif.sub);
                        exp_q.push_back(mv[SW+1:0]);
                    end
                    if (sif.out_valid && sif.out_ready) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sweep%0d unexpected beat: got s=%0h want no beat", g, sif.s);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("sweep%0d result", g),
                                  64'({sif.ovf, sif.cout, sif.s}), 64'(e));
                        end
                    end
                end
            end
        end
    end

endmodule
